instr_register_exec: RTL
========================

INSTR_REGISTER_EXEC -- requirements
Module: instr_register_exec

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32, meaning the number of register entries, which is 2**width of address_t.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load_en, input, 1 bit: write request, sampled every clk edge.
REQ-005 SHALL have port write_pointer, input, address_t (5 bits): write entry index.
REQ-006 SHALL have port opcode, input, opcode_t (4 bits): operation to store and execute.
REQ-007 SHALL have port operand_a, input, operand_t (signed 32 bits): first operand.
REQ-008 SHALL have port operand_b, input, operand_t (signed 32 bits): second operand.
REQ-009 SHALL have port read_en, input, 1 bit: read request.
REQ-010 SHALL have port read_pointer, input, address_t (5 bits): read entry index.
REQ-011 SHALL have port instruction_word, output, instruction_t: the entry read back, with fields opc, op_a, op_b and rez (signed 64 bits).
REQ-012 SHALL have port read_valid, output, 1 bit: instruction_word is valid for one cycle.
REQ-013 SHALL have port entry_valid, output, 1 bit: the entry read had been written since reset.
REQ-014 SHALL have port busy, output, 1 bit: a write is in the execute pipeline.

Function
REQ-015 SHALL capture opcode, operands and write_pointer into stage 1 on every edge where load_en=1.
REQ-016 SHALL compute rez in stage 2 from the stage-1 registers and commit the entry plus its valid bit at the end of stage 2, giving a write commit latency of 2 cycles from the load_en edge.
REQ-017 SHALL accept back-to-back writes, one per cycle, with no stall.
REQ-018 SHALL compute rez per opcode: ZERO gives 0; PASSA gives op_a; PASSB gives op_b; ADD gives a+b; SUB gives a-b; MULT gives a*b; DIV gives a/b; MOD gives a%b.
REQ-019 SHALL perform all arithmetic signed and sign-extended to 64 bits, with no overflow possible.
REQ-020 SHALL give rez=0 for DIV or MOD with op_b=0.
REQ-021 SHALL give rez=0 for any opcode encoding outside the enumeration.
REQ-022 SHALL register instruction_word on an edge with read_en=1 and assert read_valid for exactly the following cycle.
REQ-023 SHALL return the array contents as they stood before that edge's commit, so a read of an entry being committed on the same edge returns the old contents.
REQ-024 SHALL return all-zero fields with entry_valid=0 for a read of a never-written entry.
REQ-025 SHALL keep the last committed write when two commits target the same address.
REQ-026 SHALL hold instruction_word when read_en=0 and drive read_valid=0.
REQ-027 SHALL drive busy=1 when either pipeline stage holds a valid write.
REQ-028 SHALL wrap pointers modulo NUM_ENTRIES with no out-of-range access.

Reset
REQ-029 SHALL, on a clk edge with reset=1, clear all entries and valid bits, both pipeline stages, instruction_word, read_valid, entry_valid and busy to 0.
REQ-030 SHALL discard an in-flight write when reset is asserted mid-pipeline, so that it never commits.
REQ-031 SHALL ignore load_en and read_en while reset=1.

Configuration
REQ-032 SHALL support macro INSTR_REG_DIV_EN: when defined, DIV and MOD are implemented as in REQ-018 and REQ-020.
REQ-033 SHALL, when INSTR_REG_DIV_EN is undefined, give rez=0 for DIV and MOD and instantiate no divider logic.

Structure
REQ-034 SHALL take operand_t, opcode_t, address_t, instruction_t and NUM_ENTRIES from instr_register_pkg.
REQ-035 SHALL place the rez computation in a combinational sub-module instr_alu, instantiated in stage 2.

Verification
REQ-036 SHALL verify reset: hold reset 2 cycles, then read address 5 -> read_valid=1, entry_valid=0, all fields 0.
REQ-037 SHALL verify ADD: write addr 3, ADD, a=-5, b=7, then read 3 at least 2 cycles later -> opc=ADD, op_a=-5, op_b=7, rez=2, entry_valid=1.
REQ-038 SHALL verify MULT and DIV: write addr 0 MULT a=-15 b=15 and addr 1 DIV a=9 b=0 -> rez=-225 and rez=0; with INSTR_REG_DIV_EN, DIV a=-9 b=2 -> rez=-4.
REQ-039 SHALL verify the same-edge hazard: write addr 31 PASSA a=1, later write addr 31 PASSA a=2 and read 31 on its commit edge -> read shows rez=1; the next read shows rez=2.
REQ-040 SHALL verify reset mid-operation: load_en at addr 7, reset on the next edge -> busy=0, and a later read of 7 -> entry_valid=0.
REQ-041 SHALL verify back-to-back writes: write addrs 0..31, then read all -> each matches its write, busy high during writes and low 2 cycles after the last.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register/execute block.
// Configuration macro: INSTR_REG_DIV_EN (enables DIV/MOD in instr_alu).
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);

  typedef logic [ADDR_W-1:0]  address_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rez;
  } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational result generator for one instruction.
// Configuration macro: INSTR_REG_DIV_EN -- when undefined, DIV and MOD
// return 0 and no divider is built.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  rez
);

  result_t a_ext_s;
  result_t b_ext_s;

  // Sign-extend both operands so every result fits in 64 bits.
  assign a_ext_s = result_t'(op_a);
  assign b_ext_s = result_t'(op_b);

  // Select the result for the opcode; unknown encodings yield zero.
  always_comb begin
    rez = 64'sd0;
    case (opc)
      ZERO:  rez = 64'sd0;
      PASSA: rez = a_ext_s;
      PASSB: rez = b_ext_s;
      ADD:   rez = a_ext_s + b_ext_s;
      SUB:   rez = a_ext_s - b_ext_s;
      MULT:  rez = a_ext_s * b_ext_s;
`ifdef INSTR_REG_DIV_EN
      DIV: begin
        if (b_ext_s == 64'sd0) begin
          rez = 64'sd0;
        end else begin
          rez = a_ext_s / b_ext_s;
        end
      end
      MOD: begin
        if (b_ext_s == 64'sd0) begin
          rez = 64'sd0;
        end else begin
          rez = a_ext_s % b_ext_s;
        end
      end
`else
      DIV, MOD: rez = 64'sd0;
`endif
      default: rez = 64'sd0;
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register file with a two-stage execute pipeline on the write
// path: stage 1 captures the request, stage 2 holds the computed result and
// commits it to the array on the following edge.
// Configuration macro: INSTR_REG_DIV_EN (passed through to instr_alu).
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = instr_register_pkg::NUM_ENTRIES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  address_t     write_pointer,
  input  opcode_t      opcode,
  input  operand_t     operand_a,
  input  operand_t     operand_b,
  input  logic         read_en,
  input  address_t     read_pointer,
  output instruction_t instruction_word,
  output logic         read_valid,
  output logic         entry_valid,
  output logic         busy
);

  // Stage 1: captured write request.
  logic         s1_valid_r;
  address_t     s1_addr_r;
  opcode_t      s1_opc_r;
  operand_t     s1_a_r;
  operand_t     s1_b_r;

  // Stage 2: computed entry awaiting commit.
  logic         s2_valid_r;
  address_t     s2_addr_r;
  instruction_t s2_word_r;

  result_t      alu_rez_s;

  // Storage. Pointers are address_t wide and NUM_ENTRIES is 2**width, so
  // every pointer value indexes a real entry and wraps naturally.
  instruction_t mem_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ent_valid_r;

  instruction_t word_r;
  logic         read_valid_r;
  logic         entry_valid_r;
  logic         busy_r;

  instr_alu u_alu (
    .opc  (s1_opc_r),
    .op_a (s1_a_r),
    .op_b (s1_b_r),
    .rez  (alu_rez_s)
  );

  // Advance the write pipeline; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      s1_opc_r   <= ZERO;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s2_valid_r <= 1'b0;
      s2_addr_r  <= '0;
      s2_word_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      s1_valid_r <= load_en;
      if (load_en) begin
        s1_addr_r <= write_pointer;
        s1_opc_r  <= opcode;
        s1_a_r    <= operand_a;
        s1_b_r    <= operand_b;
      end
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_addr_r <= s1_addr_r;
        s2_word_r <= '{opc: s1_opc_r, op_a: s1_a_r, op_b: s1_b_r, rez: alu_rez_s};
      end
      // Next-cycle occupancy of either stage.
      busy_r <= load_en | s1_valid_r;
    end
  end

  // Commit the stage-2 entry into the array and mark it written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_r[i] <= '0;
      end
      ent_valid_r <= '0;
    end else if (s2_valid_r) begin
      mem_r[s2_addr_r]       <= s2_word_r;
      ent_valid_r[s2_addr_r] <= 1'b1;
    end
  end

  // Register the read port; sees array contents from before this edge's commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r        <= '0;
      read_valid_r  <= 1'b0;
      entry_valid_r <= 1'b0;
    end else if (read_en) begin
      word_r        <= mem_r[read_pointer];
      entry_valid_r <= ent_valid_r[read_pointer];
      read_valid_r  <= 1'b1;
    end else begin
      read_valid_r  <= 1'b0;
    end
  end

  assign instruction_word = word_r;
  assign read_valid       = read_valid_r;
  assign entry_valid      = entry_valid_r;
  assign busy             = busy_r;

endmodule
